// File: rtl/board_link.sv
// Two-board serial link: frames the local send_* levels onto tx and recovers the peer's
// levels from rx, with parity/stop checking and a link timeout.
module board_link #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned GAP_BITS     = 4,
  parameter int unsigned TIMEOUT_CLKS = 2_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic send_connect,
  input  logic send_start,
  input  logic send_game_finish,
  input  logic rx,
  output logic tx,
  output logic receive_connect,
  output logic receive_start,
  output logic receive_game_finish,
  output logic link_up,
  output logic frame_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned GapW = $clog2(GAP_BITS + 1);
  localparam int unsigned ToW  = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [GapW-1:0] GapLast  = GapW'(GAP_BITS - 1);
  localparam logic [ToW-1:0]  ToMax    = ToW'(TIMEOUT_CLKS);

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    TxIdle, TxStart, TxD0, TxD1, TxD2, TxPar, TxStop
  } tx_state_e;

  tx_state_e       tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
  logic [2:0]      tx_data_q, tx_data_d;
  logic            tx_q, tx_d;
  logic            tx_bit_done;

  assign tx_bit_done = (tx_cnt_q == BitLast);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    gap_cnt_d  = gap_cnt_q;
    tx_data_d  = tx_data_q;
    if (tx_bit_done) begin
      tx_cnt_d = '0;
      case (tx_state_q)
        TxIdle: begin
          if (gap_cnt_q == GapLast) begin
            tx_state_d = TxStart;
            gap_cnt_d  = '0;
            // Snapshot here so a frame never mixes old and new levels.
            tx_data_d  = {send_game_finish, send_start, send_connect};
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
        TxStart: tx_state_d = TxD0;
        TxD0:    tx_state_d = TxD1;
        TxD1:    tx_state_d = TxD2;
        TxD2:    tx_state_d = TxPar;
        TxPar:   tx_state_d = TxStop;
        TxStop:  tx_state_d = TxIdle;
        default: tx_state_d = TxIdle;
      endcase
    end
  end

  // tx is registered from the next state so the line never glitches.
  always_comb begin
    tx_d = 1'b1;
    case (tx_state_d)
      TxIdle:  tx_d = 1'b1;
      TxStart: tx_d = 1'b0;
      TxD0:    tx_d = tx_data_d[0];
      TxD1:    tx_d = tx_data_d[1];
      TxD2:    tx_d = tx_data_d[2];
      TxPar:   tx_d = ^tx_data_d;
      TxStop:  tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      gap_cnt_q  <= '0;
      tx_data_q  <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      tx_data_q  <= tx_data_d;
      tx_q       <= tx_d;
    end
  end

  assign tx = tx_q;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    RxIdle, RxStart, RxData, RxPar, RxStop, RxCommit, RxWaitHigh
  } rx_state_e;

  logic            rx_meta_q, rx_sync_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [1:0]      rx_bit_q, rx_bit_d;
  logic [2:0]      rx_data_q, rx_data_d;
  logic            rx_par_q, rx_par_d;
  logic            rx_stop_q, rx_stop_d;
  logic [2:0]      receive_q, receive_d;
  logic            link_q, link_d;
  logic            err_q, err_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic            commit, bad;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_data_d  = rx_data_q;
    rx_par_d   = rx_par_q;
    rx_stop_d  = rx_stop_q;
    commit     = 1'b0;
    bad        = 1'b0;
    case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        // Idle is only entered with the line high, so low here is a falling edge.
        if (!rx_sync_q) rx_state_d = RxStart;
      end
      RxStart: begin
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d  = '0;
          rx_data_d = {rx_sync_q, rx_data_q[2:1]};
          if (rx_bit_q == 2'd2) rx_state_d = RxPar;
          else                  rx_bit_d   = rx_bit_q + 1'b1;
        end
      end
      RxPar: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d   = '0;
          rx_par_d   = rx_sync_q;
          rx_state_d = RxStop;
        end
      end
      RxStop: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d   = '0;
          rx_stop_d  = rx_sync_q;
          rx_state_d = RxCommit;
        end
      end
      RxCommit: begin
        rx_cnt_d = '0;
        if (rx_stop_q && ((^rx_data_q) == rx_par_q)) commit = 1'b1;
        else                                         bad    = 1'b1;
        // A low stop bit may be a held-low line; wait for idle before rearming.
        rx_state_d = rx_stop_q ? RxIdle : RxWaitHigh;
      end
      RxWaitHigh: begin
        rx_cnt_d = '0;
        if (rx_sync_q) rx_state_d = RxIdle;
      end
      default: begin
        rx_cnt_d   = '0;
        rx_state_d = RxIdle;
      end
    endcase
  end

  always_comb begin
    to_cnt_d  = (to_cnt_q == ToMax) ? ToMax : to_cnt_q + 1'b1;
    receive_d = receive_q;
    link_d    = link_q;
    err_d     = bad;
    if (commit) begin
      to_cnt_d  = '0;
      receive_d = rx_data_q;
      link_d    = 1'b1;
    end else if (to_cnt_d == ToMax) begin
      receive_d = '0;
      link_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_data_q  <= '0;
      rx_par_q   <= 1'b0;
      rx_stop_q  <= 1'b0;
      receive_q  <= '0;
      link_q     <= 1'b0;
      err_q      <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_data_q  <= rx_data_d;
      rx_par_q   <= rx_par_d;
      rx_stop_q  <= rx_stop_d;
      receive_q  <= receive_d;
      link_q     <= link_d;
      err_q      <= err_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign receive_connect     = receive_q[0];
  assign receive_start       = receive_q[1];
  assign receive_game_finish = receive_q[2];
  assign link_up             = link_q;
  assign frame_err           = err_q;

endmodule

// File: tb/tb_board_link.sv
// Bench for board_link: loopback and injected frames against a frame-level timing model.
module tb_board_link;
  localparam int C = 4;
  localparam int G = 2;
  localparam int T = 200;
  localparam int P = (6 + G) * C;   // frame period in clks
  localparam int L = 5 * C + 6;     // frame start on rx to commit (2 sync flops + half-bit + 5 bits)

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic send_connect = 1'b0, send_start = 1'b0, send_game_finish = 1'b0;
  logic loop = 1'b1;
  logic rx_inj = 1'b1;
  logic rx;
  logic tx, receive_connect, receive_start, receive_game_finish, link_up, frame_err;

  assign rx = loop ? tx : rx_inj;

  board_link #(
    .CLKS_PER_BIT(C),
    .GAP_BITS    (G),
    .TIMEOUT_CLKS(T)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .send_connect       (send_connect),
    .send_start         (send_start),
    .send_game_finish   (send_game_finish),
    .rx                 (rx),
    .tx                 (tx),
    .receive_connect    (receive_connect),
    .receive_start      (receive_start),
    .receive_game_finish(receive_game_finish),
    .link_up            (link_up),
    .frame_err          (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: tx waveform from the period arithmetic, rx results as scheduled events.
  typedef struct {
    int         due;
    logic [2:0] d;
    bit         good;
  } ev_t;

  ev_t        evq[$];
  int         cyc;
  logic [2:0] snap;
  logic       exp_tx, exp_link, exp_err;
  logic [2:0] exp_rcv;
  int         last_commit;

  task automatic model_reset();
    cyc = 0; snap = '0; exp_tx = 1'b1; exp_rcv = '0; exp_link = 1'b0; exp_err = 1'b0;
    last_commit = 0;
    evq.delete();
  endtask

  initial begin
    int  pos, b;
    bit  committed;
    ev_t e;
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        model_reset();
      end else begin
        cyc++;
        pos = cyc % P;
        if (pos == G * C) begin
          snap = {send_game_finish, send_start, send_connect};
          if (loop) evq.push_back(ev_t'{due: cyc + L, d: snap, good: 1'b1});
        end
        if (pos < G * C) exp_tx = 1'b1;
        else begin
          b = (pos - G * C) / C;
          if (b == 0)      exp_tx = 1'b0;
          else if (b <= 3) exp_tx = snap[b-1];
          else if (b == 4) exp_tx = ^snap;
          else             exp_tx = 1'b1;
        end
        exp_err = 1'b0;
        committed = 1'b0;
        while (evq.size() > 0 && evq[0].due <= cyc) begin
          e = evq.pop_front();
          if (e.good) begin
            exp_rcv = e.d; exp_link = 1'b1; last_commit = cyc; committed = 1'b1;
          end else begin
            exp_err = 1'b1;
          end
        end
        if (!committed && (cyc - last_commit) >= T) begin
          exp_rcv = '0; exp_link = 1'b0;
        end
      end
    end
  end

  // Compare process: every output, every cycle, against the model.
  initial forever begin
    @(negedge clk);
    check("tx", tx, exp_tx);
    check("receive", {receive_game_finish, receive_start, receive_connect}, exp_rcv);
    check("link_up", link_up, exp_link);
    check("frame_err", frame_err, exp_err);
  end

  initial forever begin
    @(negedge clk);
    if (frame_err === 1'b1) err_cnt++;
  end

  task automatic set_send(input logic [2:0] v);
    {send_game_finish, send_start, send_connect} = v;
  endtask

  task automatic wait_pos(input int p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((cyc % P) != p && n < 2 * P);
    if ((cyc % P) != p) begin
      checks++; errors++;
      $display("FAIL wait_pos: got %0d expected %0d", cyc % P, p);
    end
  endtask

  task automatic send_frame(input logic [2:0] d, input bit bad_par);
    logic [5:0] bits;
    bits = {1'b1, (^d) ^ bad_par, d, 1'b0};
    evq.push_back(ev_t'{due: cyc + L, d: d, good: !bad_par});
    for (int i = 0; i < 6; i++) begin
      rx_inj = bits[i];
      repeat (C) @(negedge clk);
    end
    rx_inj = 1'b1;
  endtask

  task automatic hold_low(input int n);
    evq.push_back(ev_t'{due: cyc + L, d: 3'b000, good: 1'b0});
    rx_inj = 1'b0;
    repeat (n) @(negedge clk);
    rx_inj = 1'b1;
  endtask

  task automatic random_loop(input int n);
    repeat (n) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) set_send(3'($urandom_range(7)));
    end
  endtask

  initial begin
    int err0;
    set_send(3'b001);
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_link", link_up, 0);
    check("reset_rcv", {receive_game_finish, receive_start, receive_connect}, 0);
    check("reset_err", frame_err, 0);
    #2 reset = 1'b1;

    // 1: connect reaches the far side within two frame periods + 3 clks
    repeat (2 * P + 3) @(negedge clk);
    check("t1_connect", receive_connect, 1);
    check("t1_link", link_up, 1);
    check("t1_no_err", err_cnt, 0);

    random_loop(400);

    // 2: mid-frame change lands in the following frame
    set_send(3'b010);
    wait_pos(0);
    wait_pos(0);
    wait_pos(G * C + 2);
    set_send(3'b110);
    repeat (25) @(negedge clk);
    check("t2_old_start", receive_start, 1);
    check("t2_old_gf", receive_game_finish, 0);
    repeat (32) @(negedge clk);
    check("t2_new_gf", receive_game_finish, 1);

    // 3: good then parity-flipped injected frame
    wait_pos(0);
    loop = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(3'b101, 1'b0);
    repeat (10) @(negedge clk);
    check("t3_good", {receive_game_finish, receive_start, receive_connect}, 3'b101);
    err0 = err_cnt;
    send_frame(3'b011, 1'b1);
    repeat (10) @(negedge clk);
    check("t3_err_pulse", err_cnt - err0, 1);
    check("t3_hold", {receive_game_finish, receive_start, receive_connect}, 3'b101);

    repeat (8) begin
      send_frame(3'($urandom_range(7)), $urandom_range(3) == 0);
      repeat ($urandom_range(3, 8)) @(negedge clk);
    end

    // 5: glitch ignored, held-low line gives exactly one error
    repeat (10) @(negedge clk);
    err0 = err_cnt;
    rx_inj = 1'b0;
    @(negedge clk);
    rx_inj = 1'b1;
    repeat (20) @(negedge clk);
    check("t5_glitch_err", err_cnt - err0, 0);
    err0 = err_cnt;
    hold_low(80);
    repeat (10) @(negedge clk);
    check("t5_low_err", err_cnt - err0, 1);

    // 4: timeout with the loop broken, then reconnect
    repeat (T + 10) @(negedge clk);
    check("t4_link_down", link_up, 0);
    check("t4_rcv_zero", {receive_game_finish, receive_start, receive_connect}, 0);
    set_send(3'b011);
    wait_pos(0);
    loop = 1'b1;
    repeat (2 * P + L) @(negedge clk);
    check("t4_link_up", link_up, 1);
    check("t4_rcv", {receive_game_finish, receive_start, receive_connect}, 3'b011);

    // 6: reset mid-frame
    wait_pos(G * C + C + 1);
    #2 reset = 1'b0;
    #1;
    check("t6_tx", tx, 1);
    check("t6_link", link_up, 0);
    check("t6_rcv", {receive_game_finish, receive_start, receive_connect}, 0);
    check("t6_err", frame_err, 0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    repeat (2 * P + L + 5) @(negedge clk);
    check("t6_link_back", link_up, 1);
    check("t6_rcv_back", {receive_game_finish, receive_start, receive_connect}, 3'b011);

    random_loop(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
